// File: rtl/byte_tx_shifter.sv
// Byte transmitter for an open-drain serial bus: shifts a byte out on SCL
// falling strobes, then samples the receiver's ACK on an SCL rising strobe.
module byte_tx_shifter #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       scl_fall,
  input  logic       scl_rise,
  input  logic       abort,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       busy,
  output logic       byte_done,
  output logic       ack_received
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       ack_nxt;

  function automatic logic head_bit(input logic [7:0] r);
    return (MSB_FIRST != 0) ? r[7] : r[0];
  endfunction

  // Move the next bit into the head position; vacated bits read as released.
  function automatic logic [7:0] shift_one(input logic [7:0] r);
    return (MSB_FIRST != 0) ? {r[6:0], 1'b1} : {1'b1, r[7:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= 8'hFF;
      bit_cnt      <= 3'd0;
      ack_received <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bit_cnt      <= bit_cnt_nxt;
      ack_received <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    ack_nxt     = ack_received;
    case (state)
      IDLE: begin
        if (load && !abort) begin
          shreg_nxt   = data_in;
          bit_cnt_nxt = 3'd0;
          ack_nxt     = 1'b0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = ACK;
          end else begin
            shreg_nxt   = shift_one(shreg);
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      ACK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (scl_rise) begin
          ack_nxt   = ~sda_in;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sda_out   = (state == SHIFT) ? head_bit(shreg) : 1'b1;
  assign busy      = (state != IDLE);
  assign byte_done = (state == DONE);

endmodule

// File: tb/tb_byte_tx_shifter.sv
// Scoreboard bench for byte_tx_shifter: an MSB-first and an LSB-first
// instance share stimulus; a monitor pops expected bits and ACK results.
module tb_byte_tx_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load;
  logic       scl_fall;
  logic       scl_rise;
  logic       abort;
  logic       sda_in;

  logic sda_m, busy_m, done_m, ack_m;
  logic sda_l, busy_l, done_l, ack_l;

  logic bit_slot;
  logic q_bit_m[$];
  logic q_bit_l[$];
  logic q_ack_m[$];
  logic q_ack_l[$];

  int checks;
  int failures;
  int done_cnt_m;
  int done_cnt_l;
  int exp_done;

  byte_tx_shifter #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .scl_fall(scl_fall), .scl_rise(scl_rise), .abort(abort), .sda_in(sda_in),
    .sda_out(sda_m), .busy(busy_m), .byte_done(done_m), .ack_received(ack_m)
  );

  byte_tx_shifter #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .scl_fall(scl_fall), .scl_rise(scl_rise), .abort(abort), .sda_in(sda_in),
    .sda_out(sda_l), .busy(busy_l), .byte_done(done_l), .ack_received(ack_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: data bits are checked on each intended bit strobe, ACK on byte_done.
  always @(negedge clk) begin
    if (bit_slot) begin
      if (q_bit_m.size() == 0) chk("bit_msb_unexpected", 1, 0);
      else chk("bit_msb", int'(sda_m), int'(q_bit_m.pop_front()));
      if (q_bit_l.size() == 0) chk("bit_lsb_unexpected", 1, 0);
      else chk("bit_lsb", int'(sda_l), int'(q_bit_l.pop_front()));
    end
    if (done_m) begin
      done_cnt_m++;
      if (q_ack_m.size() == 0) chk("done_msb_unexpected", 1, 0);
      else chk("ack_msb", int'(ack_m), int'(q_ack_m.pop_front()));
    end
    if (done_l) begin
      done_cnt_l++;
      if (q_ack_l.size() == 0) chk("done_lsb_unexpected", 1, 0);
      else chk("ack_lsb", int'(ack_l), int'(q_ack_l.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Patterns list the wire order left to right: bit 7 of the pattern goes first.
  task automatic send_bits(input logic [7:0] pm, input logic [7:0] pl,
                           input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      q_bit_m.push_back(pm[7-i]);
      q_bit_l.push_back(pl[7-i]);
      scl_fall = 1'b1;
      bit_slot = 1'b1;
      tick();
      scl_fall = 1'b0;
      bit_slot = 1'b0;
      tick();
    end
  endtask

  task automatic ack_slot(input logic sda, input logic exp_ack);
    q_ack_m.push_back(exp_ack);
    q_ack_l.push_back(exp_ack);
    exp_done++;
    sda_in   = sda;
    scl_rise = 1'b1;
    tick();
    scl_rise = 1'b0;
    sda_in   = 1'b1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy_msb"}, int'(busy_m), 0);
    chk({nm, "_busy_lsb"}, int'(busy_l), 0);
    chk({nm, "_sda_msb"},  int'(sda_m), 1);
    chk({nm, "_sda_lsb"},  int'(sda_l), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=expired required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; done_cnt_m = 0; done_cnt_l = 0; exp_done = 0;
    rst = 1'b1; data_in = 8'h00; load = 1'b0; scl_fall = 1'b0;
    scl_rise = 1'b0; abort = 1'b0; sda_in = 1'b1; bit_slot = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_done_msb", int'(done_m), 0);
    chk("reset_ack_msb", int'(ack_m), 0);
    chk("reset_ack_lsb", int'(ack_l), 0);
    rst = 1'b0;
    tick();

    // A5 with ACK low -> ack_received=1
    do_load(8'hA5);
    chk("a5_busy", int'(busy_m), 1);
    send_bits(8'b10100101, 8'b10100101, 0, 8);
    chk("a5_ack_phase_sda_msb", int'(sda_m), 1);
    chk("a5_ack_phase_sda_lsb", int'(sda_l), 1);
    ack_slot(1'b0, 1'b1);
    tick();
    chk("a5_done_one_cycle", int'(done_m), 0);
    chk("a5_ack_held", int'(ack_m), 1);

    // Back-to-back: load in the first IDLE cycle after DONE
    do_load(8'h3C);
    chk("b2b_busy_msb", int'(busy_m), 1);
    chk("b2b_busy_lsb", int'(busy_l), 1);
    send_bits(8'b00111100, 8'b00111100, 0, 8);
    ack_slot(1'b0, 1'b1);
    tick();

    // 01 with ACK high (NACK) -> ack_received=0
    do_load(8'h01);
    send_bits(8'b00000001, 8'b10000000, 0, 8);
    ack_slot(1'b1, 1'b0);
    tick();
    chk("nack_held_msb", int'(ack_m), 0);

    // Load during SHIFT is ignored
    do_load(8'hFF);
    send_bits(8'hFF, 8'hFF, 0, 3);
    data_in = 8'h00;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    chk("ign_load_sda_msb", int'(sda_m), 1);
    chk("ign_load_ack", int'(ack_m), 0);
    send_bits(8'hFF, 8'hFF, 3, 5);
    chk("ign_load_in_ack_busy", int'(busy_m), 1);
    ack_slot(1'b0, 1'b1);
    tick();

    // Abort after 4 bits
    do_load(8'h00);
    send_bits(8'h00, 8'h00, 0, 4);
    chk("abort_pre_sda_msb", int'(sda_m), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    chk("abort_ack_unchanged", int'(ack_m), 0);
    tick(); tick(); tick();

    // Reset after 4 bits
    do_load(8'h00);
    send_bits(8'h00, 8'h00, 0, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst");
    tick(); tick(); tick();

    // Simultaneous strobes on the last bit: rise must not count as the ACK sample
    do_load(8'hA5);
    send_bits(8'b10100101, 8'b10100101, 0, 7);
    q_bit_m.push_back(1'b1);
    q_bit_l.push_back(1'b1);
    scl_fall = 1'b1;
    scl_rise = 1'b1;
    sda_in   = 1'b1;
    bit_slot = 1'b1;
    tick();
    scl_fall = 1'b0;
    scl_rise = 1'b0;
    bit_slot = 1'b0;
    chk("both_busy", int'(busy_m), 1);
    chk("both_no_done", int'(done_m), 0);
    chk("both_sda", int'(sda_m), 1);
    tick();
    chk("both_waits_ack", int'(busy_m), 1);
    ack_slot(1'b0, 1'b1);
    tick();
    tick(); tick();

    chk("bits_left_msb", q_bit_m.size(), 0);
    chk("bits_left_lsb", q_bit_l.size(), 0);
    chk("acks_left_msb", q_ack_m.size(), 0);
    chk("done_count_msb", done_cnt_m, exp_done);
    chk("done_count_lsb", done_cnt_l, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_tx_shifter.md
BYTE_TX_SHIFTER -- requirements
Module: byte_tx_shifter

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning bit order: 1 = bit 7 first, 0 = bit 0 first.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port data_in, input, 8, the byte to transmit, sampled only when load is accepted.
REQ-005 SHALL have port load, input, 1, a one-cycle request to start a byte.
REQ-006 SHALL have port scl_fall, input, 1, a one-cycle strobe to advance to the next bit.
REQ-007 SHALL have port scl_rise, input, 1, a one-cycle strobe to sample the ACK bit.
REQ-008 SHALL have port abort, input, 1, a one-cycle request to cancel the byte.
REQ-009 SHALL have port sda_in, input, 1, the sampled bus data line.
REQ-010 SHALL have port sda_out, output, 1, the driven data bit; 1 means released.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port byte_done, output, 1, a one-cycle pulse when the byte and ACK slot are complete.
REQ-013 SHALL have port ack_received, output, 1, the ACK result, held until the next accepted load.

Function
REQ-014 SHALL implement states IDLE, SHIFT, ACK and DONE, registered.
REQ-015 SHALL, in IDLE with load=1, latch data_in into an 8-bit shift register, clear bit_cnt (3-bit), clear ack_received and go to SHIFT on the next edge.
REQ-016 SHALL drive sda_out in SHIFT with the current head bit (bit 7 if MSB_FIRST, else bit 0), valid the cycle after load is accepted.
REQ-017 SHALL, in SHIFT on scl_fall with bit_cnt<7, shift the register one place toward the head, fill with 1, and increment bit_cnt.
REQ-018 SHALL, in SHIFT on scl_fall with bit_cnt==7, go to ACK and drive sda_out=1 from the next cycle.
REQ-019 SHALL, in ACK on scl_rise, set ack_received = ~sda_in and go to DONE.
REQ-020 SHALL, in DONE, assert byte_done for exactly one cycle, keep sda_out=1, and return to IDLE on the next edge.
REQ-021 SHALL drive sda_out=1 in IDLE, ACK and DONE.
REQ-022 SHALL ignore scl_rise in SHIFT and scl_fall in ACK.
REQ-023 SHALL, when scl_rise and scl_fall are both asserted in the same cycle, act only on the strobe relevant to the current state (per REQ-017/018/019/022).
REQ-024 SHALL ignore load when not in IDLE; the shift register and bit_cnt are unaffected.
REQ-025 SHALL, on abort in any non-IDLE state, go to IDLE on the next edge with sda_out=1, no byte_done pulse, and ack_received unchanged.
REQ-026 SHALL give abort priority over load, scl_fall and scl_rise in the same cycle.
REQ-027 SHALL make the minimum load-to-byte_done latency 1 + 8 scl_fall + 1 scl_rise + 1 cycle; there is no timeout.
REQ-028 SHALL accept a load in the first IDLE cycle after DONE (back-to-back bytes).

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear state to IDLE, the shift register to 8'hFF, bit_cnt to 0, sda_out to 1, busy to 0, byte_done to 0 and ack_received to 0.
REQ-030 SHALL give rst priority over all other inputs; a reset mid-byte discards the byte with no byte_done pulse.

Verification
REQ-031 SHALL check: MSB_FIRST=1, load data_in=8'hA5, 8 scl_fall, sda_in=0 at scl_rise -> sda_out sequence 1,0,1,0,0,1,0,1; then sda_out=1; ack_received=1; one byte_done pulse.
REQ-032 SHALL check: MSB_FIRST=0, data_in=8'h01, sda_in=1 at the ACK scl_rise -> sda_out sequence 1,0,0,0,0,0,0,0; ack_received=0; byte_done pulses.
REQ-033 SHALL check: load=1 with data_in=8'h00 during SHIFT after 3 bits of 8'hFF -> remaining bits all 1; ack_received unaffected by the ignored load.
REQ-034 SHALL check: abort, or rst=1, after 4 scl_fall -> IDLE next edge; sda_out=1; busy=0; no byte_done.
REQ-035 SHALL check: scl_rise and scl_fall together in the SHIFT cycle after bit 7 -> goes to ACK; the scl_rise is not taken as the ACK sample.
REQ-036 SHALL check: load in the cycle after byte_done with 8'h3C -> a second byte is transmitted correctly with no gap state.
